// File: rtl/countdown_timer.sv
// countdown_timer: loadable MM:SS down-counter with start/pause, reload, clear
// and alarm-acknowledge control.
//
// Counts a preset duration down by one second per `tick` strobe. Reaching 00:00
// from a running count sets the sticky `alarm` flag and pulses `done` for one
// cycle. Control inputs resolve by priority clear > load > start > tick; `ack`
// acts alongside that chain and only clears the alarm (plus EXPIRED -> IDLE).
//
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN - when defined, expiry reloads the count from the
//   reload register and keeps running (EXPIRED only if the reload value is
//   00:00); `ack` then only clears the alarm.
//
// Parameters:
//   MIN_W    width of the minutes field
//   MAX_MIN  largest loadable minute value (must be < 2**MIN_W)
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   tick      one-cycle count enable (1 Hz strobe)
//   load      capture load_min/load_sec as count and reload value
//   load_min  preset minutes
//   load_sec  preset seconds
//   start     one-cycle start/pause toggle
//   clear     abort to IDLE with count and reload value zeroed
//   ack       acknowledge/silence alarm
//   min       current minutes
//   sec       current seconds, 0..59
//   running   high while in RUN
//   alarm     sticky expiry flag
//   done      one-cycle expiry pulse
module countdown_timer #(
    parameter int unsigned MIN_W   = 7,
    parameter int unsigned MAX_MIN = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    input  logic             start,
    input  logic             clear,
    input  logic             ack,
    output logic [MIN_W-1:0] min,
    output logic [5:0]       sec,
    output logic             running,
    output logic             alarm,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StExpired
    } state_e;

    localparam logic [5:0]       SecMax = 6'd59;
    localparam logic [MIN_W-1:0] MinMax = MIN_W'(MAX_MIN);
    localparam logic [MIN_W-1:0] MinOne = MIN_W'(1);

    state_e           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [MIN_W-1:0] rmin_q, rmin_d;
    logic [5:0]       rsec_q, rsec_d;
    logic             alarm_q, alarm_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    logic [MIN_W-1:0] load_min_c;
    logic [5:0]       load_sec_c;
    logic [MIN_W-1:0] dec_min;
    logic [5:0]       dec_sec;
    logic             count_zero;
    logic             count_one;
    logic             expire;

    // Out-of-range presets saturate rather than wrap.
    assign load_sec_c = (load_sec > SecMax) ? SecMax : load_sec;
    assign load_min_c = (load_min > MinMax) ? MinMax : load_min;

    assign count_zero = (min_q == '0) && (sec_q == '0);
    assign count_one  = (min_q == '0) && (sec_q == 6'd1);

    // One-second decrement with borrow from minutes. Only used when the count
    // is non-zero, so the minute borrow can never underflow.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != '0) begin
            dec_sec = sec_q - 6'd1;
        end else begin
            dec_sec = SecMax;
            dec_min = min_q - MinOne;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        rmin_d  = rmin_q;
        rsec_d  = rsec_q;
        alarm_d = alarm_q;
        expire  = 1'b0;

        // ack sits outside the priority chain; whatever the chain does below
        // overrides it, which lets a same-cycle expiry keep the alarm set.
        if (ack) begin
            alarm_d = 1'b0;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
            if (state_q == StExpired) begin
                state_d = StIdle;
            end
`endif
        end

        if (clear) begin
            min_d   = '0;
            sec_d   = '0;
            rmin_d  = '0;
            rsec_d  = '0;
            alarm_d = 1'b0;
            state_d = StIdle;
        end else if (load) begin
            min_d  = load_min_c;
            sec_d  = load_sec_c;
            rmin_d = load_min_c;
            rsec_d = load_sec_c;
            if (state_q == StExpired) begin
                state_d = StIdle;
            end
        end else if (start) begin
            case (state_q)
                StIdle: begin
                    if (!count_zero) begin
                        state_d = StRun;
                    end
                end
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: ;
            endcase
        end else if (tick && (state_q == StRun) && !count_zero) begin
            min_d = dec_min;
            sec_d = dec_sec;
            if (count_one) begin
                expire  = 1'b1;
                alarm_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if ((rmin_q != '0) || (rsec_q != '0)) begin
                    min_d = rmin_q;
                    sec_d = rsec_q;
                end else begin
                    state_d = StExpired;
                end
`else
                state_d = StExpired;
`endif
            end
        end

        done_d    = expire;
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            min_q     <= '0;
            sec_q     <= '0;
            rmin_q    <= '0;
            rsec_q    <= '0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            rmin_q    <= rmin_d;
            rsec_q    <= rsec_d;
            alarm_q   <= alarm_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign min     = min_q;
    assign sec     = sec_q;
    assign running = running_q;
    assign alarm   = alarm_q;
    assign done    = done_q;

`ifndef SYNTHESIS
    a_sec_range: assert property (@(posedge clk) disable iff (reset) sec_q <= SecMax);
    a_min_range: assert property (@(posedge clk) disable iff (reset) min_q <= MinMax);
    a_done_alarm: assert property (@(posedge clk) disable iff (reset) done_q |-> alarm_q);
    a_running_state: assert property (@(posedge clk) disable iff (reset)
                                      running_q == (state_q == StRun));
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-scenario tasks drive control
// tables, push the expected outputs to a scoreboard queue and pop/compare them
// once the registered outputs settle after each clock edge.
module tb_countdown_timer;

    localparam int unsigned MIN_W = 7;

    localparam int TICK  = 1;
    localparam int LOAD  = 2;
    localparam int START = 4;
    localparam int CLEAR = 8;
    localparam int ACK   = 16;

    typedef struct {
        int          ctl;
        int          lm;
        int          ls;
        logic [15:0] e;
    } step_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             load = 1'b0;
    logic [MIN_W-1:0] load_min = '0;
    logic [5:0]       load_sec = '0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             ack = 1'b0;
    logic [MIN_W-1:0] min;
    logic [5:0]       sec;
    logic             running;
    logic             alarm;
    logic             done;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    countdown_timer #(
        .MIN_W  (MIN_W),
        .MAX_MIN(99)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .clear   (clear),
        .ack     (ack),
        .min     (min),
        .sec     (sec),
        .running (running),
        .alarm   (alarm),
        .done    (done)
    );

    function automatic logic [15:0] pack(input int m, input int s, input int r, input int a,
                                         input int d);
        logic [15:0] v;
        v = {m[6:0], s[5:0], r[0], a[0], d[0]};
        return v;
    endfunction

    function automatic logic [15:0] observe();
        return {min, sec, running, alarm, done};
    endfunction

    function automatic step_t mk(input int ctl, input int lm, input int ls, input int m,
                                 input int s, input int r, input int a, input int d);
        step_t st;
        st.ctl = ctl;
        st.lm  = lm;
        st.ls  = ls;
        st.e   = pack(m, s, r, a, d);
        return st;
    endfunction

    // Apply one cycle of control inputs, then return 1 time unit after the edge.
    task automatic drive(input step_t st);
        logic [6:0] lm;
        logic [5:0] ls;
        lm       = st.lm[6:0];
        ls       = st.ls[5:0];
        tick     = st.ctl[0];
        load     = st.ctl[1];
        start    = st.ctl[2];
        clear    = st.ctl[3];
        ack      = st.ctl[4];
        load_min = lm;
        load_sec = ls;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got, e;
        load     = 1'b1;
        load_min = 7'd5;
        load_sec = 6'd5;
        tick     = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_held: got %h expected %h", got, e);
        end
        load  = 1'b0;
        tick  = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", got, e);
        end
    endtask

    task automatic test_countdown();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 1, 2, 1, 2, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 1, 2, 1, 0, 0));
        for (int i = 1; i <= 62; i++) begin
            int t;
            t = 62 - i;
            st.push_back(mk(TICK, 0, 0, t / 60, t % 60, (t != 0) ? 1 : 0, (t == 0) ? 1 : 0,
                            (t == 0) ? 1 : 0));
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(mk(TICK, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(mk(START, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(mk(ACK, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL countdown step %0d: got %0d:%0d run=%0b alarm=%0b done=%0b, expected %0d:%0d run=%0b alarm=%0b done=%0b",
                         i, got[15:9], got[8:3], got[2], got[1], got[0],
                         e[15:9], e[8:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_clamp();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 120, 63, 99, 59, 0, 0, 0));
        st.push_back(mk(LOAD, 99, 59, 99, 59, 0, 0, 0));
        st.push_back(mk(LOAD, 100, 60, 99, 59, 0, 0, 0));
        st.push_back(mk(LOAD, 5, 30, 5, 30, 0, 0, 0));
        st.push_back(mk(CLEAR, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL clamp step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_pause();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 0, 10, 0, 10, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 10, 1, 0, 0));
        for (int i = 1; i <= 3; i++) st.push_back(mk(TICK, 0, 0, 0, 10 - i, 1, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 7, 0, 0, 0));
        for (int i = 1; i <= 5; i++) st.push_back(mk(TICK, 0, 0, 0, 7, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 7, 1, 0, 0));
        for (int i = 1; i <= 6; i++) st.push_back(mk(TICK, 0, 0, 0, 7 - i, 1, 0, 0));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        st.push_back(mk(TICK, 0, 0, 0, 10, 1, 1, 1));
        st.push_back(mk(CLEAR, 0, 0, 0, 0, 0, 0, 0));
`else
        st.push_back(mk(TICK, 0, 0, 0, 0, 0, 1, 1));
        // start is ignored in EXPIRED; the same-cycle ack still returns to IDLE
        st.push_back(mk(ACK | START, 0, 0, 0, 0, 0, 0, 0));
`endif
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL pause step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_priority();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 0, 20, 0, 20, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 20, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 19, 1, 0, 0));
        st.push_back(mk(LOAD | TICK, 0, 30, 0, 30, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 29, 1, 0, 0));
        st.push_back(mk(CLEAR | START, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(LOAD | START, 0, 15, 0, 15, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 15, 1, 0, 0));
        st.push_back(mk(CLEAR | LOAD, 0, 40, 0, 0, 0, 0, 0));
        st.push_back(mk(LOAD, 2, 0, 2, 0, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 2, 0, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 1, 59, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 1, 58, 1, 0, 0));
        st.push_back(mk(CLEAR, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL priority step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_ack_expiry();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 0, 2, 0, 2, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 2, 1, 0, 0));
        st.push_back(mk(ACK, 0, 0, 0, 2, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 1, 1, 0, 0));
        st.push_back(mk(TICK | ACK, 0, 0, 0, 0, 0, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        st.push_back(mk(ACK, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(LOAD, 0, 3, 0, 3, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 3, 1, 0, 0));
        st.push_back(mk(LOAD, 0, 1, 0, 1, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 0, 0, 1, 1));
        // load leaves EXPIRED for IDLE but does not touch the alarm
        st.push_back(mk(LOAD, 0, 5, 0, 5, 0, 1, 0));
        st.push_back(mk(START, 0, 0, 0, 5, 1, 1, 0));
        st.push_back(mk(ACK, 0, 0, 0, 5, 1, 0, 0));
        st.push_back(mk(CLEAR, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL ack_expiry step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 0, 6, 0, 6, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 6, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 5, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 4, 1, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, got, e);
            end
        end
        // Reset between edges must clear outputs without waiting for a clock.
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", got, e);
        end
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_after: got %h expected %h", got, e);
        end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        step_t st[$];
        logic [15:0] got, e;
        st.push_back(mk(LOAD, 0, 2, 0, 2, 0, 0, 0));
        st.push_back(mk(START, 0, 0, 0, 2, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 1, 1, 0, 0));
        st.push_back(mk(TICK, 0, 0, 0, 2, 1, 1, 1));
        st.push_back(mk(TICK, 0, 0, 0, 1, 1, 1, 0));
        st.push_back(mk(TICK, 0, 0, 0, 2, 1, 1, 1));
        st.push_back(mk(ACK, 0, 0, 0, 2, 1, 0, 0));
        st.push_back(mk(CLEAR, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(st[i].e);
            got = observe();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL auto_reload step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown();
        test_ack_expiry();
`endif
        test_clamp();
        test_pause();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
